latch_seq: RTL and testbench
============================

LATCH_SEQ -- requirements
Module: latch_seq

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving the NAND bus width (8 or 16).
REQ-002 The block SHALL have parameter MAX_CYC, default 5, giving the maximum number of latch cycles per burst (1..8).
REQ-003 The block SHALL have parameters T_WP, T_WH and T_CLH, defaults 3, 2 and 2, giving clock counts for WE# low, WE# high and CLE hold.
REQ-004 The block SHALL have parameter T_WB, default 5, giving the clock count of the post-command wait.
REQ-005 Port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-006 Port nreset, input, 1 bit: synchronous, active-low reset.
REQ-007 Port activate, input, 1 bit: start request, sampled only while idle.
REQ-008 Port latch_type, input, 1 bit: 0 = command (CLE), 1 = address (ALE).
REQ-009 Port count, input, 3 bits: number of latch cycles minus 1; values at or above MAX_CYC are clamped to MAX_CYC-1.
REQ-010 Port data_in, input, DATA_W*MAX_CYC bits: packed words, word 0 in the LSBs and issued first.
REQ-011 Port latch_ctrl, output, 1 bit: CLE or ALE strobe, active high.
REQ-012 Port write_enable, output, 1 bit: WE#, active low.
REQ-013 Port data_out, output, DATA_W bits: NAND I/O drive value.
REQ-014 Port busy, output, 1 bit: high while a burst is in progress.
REQ-015 Port done, output, 1 bit: one-cycle pulse when a burst completes.

Function
REQ-016 All outputs SHALL be registered.
REQ-017 The FSM SHALL have states IDLE, SETUP, HOLD and WB_WAIT.
REQ-018 In IDLE, when activate=1 at edge k, the block SHALL capture data_in, latch_type and count, clear the index i to 0, and enter SETUP, with outputs changing from edge k onward.
REQ-019 In SETUP, for T_WP cycles, the block SHALL drive write_enable=0, latch_ctrl=1 and data_out=word[i], then go to HOLD.
REQ-020 In HOLD, the block SHALL drive write_enable=1, latch_ctrl=1 and data_out=word[i] for T_WH cycles, or for T_CLH cycles on the last word of a command burst.
REQ-021 On HOLD exit with i<count, the block SHALL increment i and return to SETUP.
REQ-022 On HOLD exit with i==count, the block SHALL go to WB_WAIT if latch_type=0 and LATCH_SEQ_WB_WAIT_EN is defined, and otherwise to IDLE.
REQ-023 In WB_WAIT, the block SHALL drive latch_ctrl=0, write_enable=1 and data_out=0 for T_WB cycles, then go to IDLE.
REQ-024 busy SHALL equal (state != IDLE).
REQ-025 done SHALL be 1 for exactly the first cycle in IDLE after a burst.
REQ-026 In IDLE, the block SHALL drive latch_ctrl=0, write_enable=1 and data_out=0.
REQ-027 activate SHALL be ignored while busy=1, with no queuing.
REQ-028 activate held high SHALL start a new burst on the cycle after done.
REQ-029 A timing parameter set to 0 SHALL behave as 1.
REQ-030 The per-phase down-counter SHALL be 8 bits wide; parameters above 255 are illegal and SHALL be rejected by elaboration-time assertion.
REQ-031 The total busy length of a burst SHALL be (count+1)*(T_WP+T_WH), plus (T_CLH-T_WH) for command bursts, plus T_WB when waiting.

Reset
REQ-032 When nreset=0 at a rising edge, the block SHALL go to IDLE, clear i and the counter, and set latch_ctrl=0, write_enable=1, data_out=0, busy=0 and done=0.
REQ-033 Reset SHALL abort any burst immediately with no done pulse.
REQ-034 Reset SHALL take priority over activate.

Configuration
REQ-035 Macro LATCH_SEQ_WB_WAIT_EN SHALL control the WB_WAIT state.
REQ-036 With LATCH_SEQ_WB_WAIT_EN defined, command bursts SHALL append WB_WAIT (tWB) before done/idle, and address bursts SHALL be unaffected.
REQ-037 Without LATCH_SEQ_WB_WAIT_EN, the WB_WAIT state and its logic SHALL be absent and the T_WB parameter SHALL be ignored; the issuing component then owns tWB.

Structure
REQ-038 Package latch_seq_pkg SHALL hold the FSM state enum, constants LATCH_CMD=1'b0 and LATCH_ADDR=1'b1, and default timing constants.
REQ-039 Sub-module latch_timer SHALL implement the loadable 8-bit down-counter with load, value and expired ports, shared by all timed states.

Verification (defaults, DATA_W=8, MAX_CYC=5)
REQ-040 Command 0x70 (type=0, count=0), macro off: cycles 1-3 show write_enable=0, latch_ctrl=1, data_out=0x70; cycles 4-5 show write_enable=1, latch_ctrl=1; cycle 6 shows busy=0, done=1, data_out=0.
REQ-041 Address 0x00,0x00,0x10,0x00,0x01 (type=1, count=4): five WE# low pulses of 3 cycles each carrying the words in order, busy high for 25 cycles, and exactly one done pulse.
REQ-042 Same command with LATCH_SEQ_WB_WAIT_EN defined: busy high for 10 cycles, latch_ctrl=0 during the last 5, done on cycle 11.
REQ-043 nreset=0 during the 3rd word of an address burst: next cycle shows busy=0, write_enable=1, latch_ctrl=0 and no done pulse; a new activate then runs normally.
REQ-044 activate pulsed mid-burst is ignored; activate held high yields back-to-back bursts separated by exactly one IDLE/done cycle.
REQ-045 count=7 with MAX_CYC=5 is clamped to 5 words; T_WP=0 yields a 1-cycle WE# low pulse.

Source files
------------

// File: rtl/latch_seq_pkg.sv
// Shared types and constants for the NAND command/address latch sequencer.
// The WB_WAIT state only exists when LATCH_SEQ_WB_WAIT_EN is defined.
package latch_seq_pkg;

   localparam int unsigned TMR_W = 8;

   localparam logic LATCH_CMD  = 1'b0;
   localparam logic LATCH_ADDR = 1'b1;

   localparam int unsigned DEF_DATA_W  = 8;
   localparam int unsigned DEF_MAX_CYC = 5;
   localparam int unsigned DEF_T_WP    = 3;
   localparam int unsigned DEF_T_WH    = 2;
   localparam int unsigned DEF_T_CLH   = 2;
   localparam int unsigned DEF_T_WB    = 5;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SETUP   = 2'd1,
      HOLD    = 2'd2
`ifdef LATCH_SEQ_WB_WAIT_EN
      ,
      WB_WAIT = 2'd3
`endif
   } state_t;

   // Timer preload for a phase of cyc clocks; a zero-length phase still lasts one clock.
   function automatic logic [TMR_W-1:0] phase_load(input int unsigned cyc);
      return (cyc <= 1) ? '0 : TMR_W'(cyc - 1);
   endfunction

endpackage

// File: rtl/latch_seq_timer.sv
// Loadable 8-bit down-counter shared by every timed state of latch_seq.
module latch_timer
   import latch_seq_pkg::*;
(
   input  logic             clk,
   input  logic             nreset,
   input  logic             load,
   input  logic [TMR_W-1:0] load_val,
   output logic [TMR_W-1:0] value,
   output logic             expired
);

   // expired is registered alongside value so it is valid in the same cycle value reaches 0.
   always_ff @(posedge clk) begin
      if (!nreset) begin
         value   <= '0;
         expired <= 1'b1;
      end else if (load) begin
         value   <= load_val;
         expired <= (load_val == '0);
      end else if (value != '0) begin
         value   <= value - TMR_W'(1);
         expired <= (value == TMR_W'(1));
      end else begin
         expired <= 1'b1;
      end
   end

endmodule

// File: rtl/latch_seq.sv
// NAND CLE/ALE latch sequencer: issues 1..MAX_CYC bus words with WE# timing.
// Optional macro LATCH_SEQ_WB_WAIT_EN appends a tWB wait after command bursts.
module latch_seq
   import latch_seq_pkg::*;
#(
   parameter int unsigned DATA_W  = DEF_DATA_W,
   parameter int unsigned MAX_CYC = DEF_MAX_CYC,
   parameter int unsigned T_WP    = DEF_T_WP,
   parameter int unsigned T_WH    = DEF_T_WH,
   parameter int unsigned T_CLH   = DEF_T_CLH,
   parameter int unsigned T_WB    = DEF_T_WB
) (
   input  logic                      clk,
   input  logic                      nreset,
   input  logic                      activate,
   input  logic                      latch_type,
   input  logic [2:0]                count,
   input  logic [DATA_W*MAX_CYC-1:0] data_in,
   output logic                      latch_ctrl,
   output logic                      write_enable,
   output logic [DATA_W-1:0]         data_out,
   output logic                      busy,
   output logic                      done
);

   localparam int unsigned BUS_W    = DATA_W * MAX_CYC;
   localparam logic [2:0]  LAST_MAX = 3'(MAX_CYC - 1);

   if (T_WP > 255 || T_WH > 255 || T_CLH > 255 || T_WB > 255) begin : g_bad_timing
      $error("latch_seq: timing parameter exceeds the 8-bit phase counter");
   end
   if (MAX_CYC < 1 || MAX_CYC > 8) begin : g_bad_max_cyc
      $error("latch_seq: MAX_CYC must be in 1..8");
   end
   if (DATA_W != 8 && DATA_W != 16) begin : g_bad_data_w
      $error("latch_seq: DATA_W must be 8 or 16");
   end

   state_t               state_q, state_nxt;
   logic [BUS_W-1:0]     data_q, data_nxt;
   logic [2:0]           idx_q, idx_nxt;
   logic [2:0]           cnt_q, cnt_nxt;
   logic                 type_q, type_nxt;
   logic [2:0]           cnt_clamped;

   logic                 tmr_load;
   logic [TMR_W-1:0]     tmr_load_val;
   logic [TMR_W-1:0]     tmr_value_unused;
   logic                 tmr_expired;

   logic                 latch_ctrl_d, write_enable_d, busy_d, done_d;
   logic [DATA_W-1:0]    data_out_d;

   latch_timer u_timer (
      .clk      (clk),
      .nreset   (nreset),
      .load     (tmr_load),
      .load_val (tmr_load_val),
      .value    (tmr_value_unused),
      .expired  (tmr_expired)
   );

   // State, burst context and registered outputs.
   always_ff @(posedge clk) begin
      if (!nreset) begin
         state_q      <= IDLE;
         data_q       <= '0;
         idx_q        <= '0;
         cnt_q        <= '0;
         type_q       <= LATCH_CMD;
         latch_ctrl   <= 1'b0;
         write_enable <= 1'b1;
         data_out     <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
      end else begin
         state_q      <= state_nxt;
         data_q       <= data_nxt;
         idx_q        <= idx_nxt;
         cnt_q        <= cnt_nxt;
         type_q       <= type_nxt;
         latch_ctrl   <= latch_ctrl_d;
         write_enable <= write_enable_d;
         data_out     <= data_out_d;
         busy         <= busy_d;
         done         <= done_d;
      end
   end

   // Next state; the word register shifts so the current word always sits in the LSBs.
   always_comb begin
      state_nxt   = state_q;
      data_nxt    = data_q;
      idx_nxt     = idx_q;
      cnt_nxt     = cnt_q;
      type_nxt    = type_q;
      cnt_clamped = (32'(count) >= MAX_CYC) ? LAST_MAX : count;
      case (state_q)
         IDLE: begin
            if (activate) begin
               state_nxt = SETUP;
               data_nxt  = data_in;
               idx_nxt   = '0;
               cnt_nxt   = cnt_clamped;
               type_nxt  = latch_type;
            end
         end
         SETUP: begin
            if (tmr_expired) state_nxt = HOLD;
         end
         HOLD: begin
            if (tmr_expired) begin
               if (idx_q != cnt_q) begin
                  state_nxt = SETUP;
                  idx_nxt   = idx_q + 3'd1;
                  data_nxt  = data_q >> DATA_W;
               end
`ifdef LATCH_SEQ_WB_WAIT_EN
               else if (type_q == LATCH_CMD) begin
                  state_nxt = WB_WAIT;
               end
`endif
               else begin
                  state_nxt = IDLE;
               end
            end
         end
`ifdef LATCH_SEQ_WB_WAIT_EN
         WB_WAIT: begin
            if (tmr_expired) state_nxt = IDLE;
         end
`endif
         default: state_nxt = IDLE;
      endcase
   end

   // Output and timer-load decode from the state being entered, so outputs lead by one edge.
   always_comb begin
      latch_ctrl_d   = 1'b0;
      write_enable_d = 1'b1;
      data_out_d     = '0;
      busy_d         = (state_nxt != IDLE);
      done_d         = (state_q != IDLE) && (state_nxt == IDLE);
      tmr_load       = (state_nxt != state_q);
      tmr_load_val   = '0;
      case (state_nxt)
         SETUP: begin
            latch_ctrl_d   = 1'b1;
            write_enable_d = 1'b0;
            data_out_d     = data_nxt[DATA_W-1:0];
            tmr_load_val   = phase_load(T_WP);
         end
         HOLD: begin
            latch_ctrl_d = 1'b1;
            data_out_d   = data_nxt[DATA_W-1:0];
            tmr_load_val = (idx_nxt == cnt_nxt && type_nxt == LATCH_CMD) ?
                           phase_load(T_CLH) : phase_load(T_WH);
         end
`ifdef LATCH_SEQ_WB_WAIT_EN
         WB_WAIT: begin
            tmr_load_val = phase_load(T_WB);
         end
`endif
         default: ;
      endcase
   end

endmodule

// File: tb/tb_latch_seq.sv
// Directed self-checking bench for latch_seq (default instance plus a T_WP=0 instance).
// Expectations adapt to LATCH_SEQ_WB_WAIT_EN when it is defined.
module tb_latch_seq;

`ifdef LATCH_SEQ_WB_WAIT_EN
   localparam int WB = 5;
`else
   localparam int WB = 0;
`endif
   localparam int CMD_LEN = 5 + WB;

   logic        clk = 1'b0;
   logic        nreset = 1'b0;
   logic        activate = 1'b0;
   logic        activate0 = 1'b0;
   logic        latch_type = 1'b0;
   logic [2:0]  count = 3'd0;
   logic [39:0] data_in = '0;

   logic        latch_ctrl, write_enable, busy, done;
   logic [7:0]  data_out;
   logic        latch_ctrl_0, write_enable_0, busy_0, done_0;
   logic [7:0]  data_out_0;

   int checks = 0;
   int errors = 0;

   bit          sel0 = 1'b0;
   logic        tr_we    [0:127];
   logic        tr_latch [0:127];
   logic        tr_busy  [0:127];
   logic [7:0]  tr_data  [0:127];
   int          tr_done_at;

   wire         s_we    = sel0 ? write_enable_0 : write_enable;
   wire         s_latch = sel0 ? latch_ctrl_0   : latch_ctrl;
   wire         s_busy  = sel0 ? busy_0         : busy;
   wire         s_done  = sel0 ? done_0         : done;
   wire [7:0]   s_data  = sel0 ? data_out_0     : data_out;

   always #5 clk = ~clk;

   latch_seq dut (
      .clk(clk), .nreset(nreset), .activate(activate), .latch_type(latch_type),
      .count(count), .data_in(data_in), .latch_ctrl(latch_ctrl),
      .write_enable(write_enable), .data_out(data_out), .busy(busy), .done(done)
   );

   latch_seq #(.T_WP(0)) dut0 (
      .clk(clk), .nreset(nreset), .activate(activate0), .latch_type(latch_type),
      .count(count), .data_in(data_in), .latch_ctrl(latch_ctrl_0),
      .write_enable(write_enable_0), .data_out(data_out_0), .busy(busy_0), .done(done_0)
   );

   // Starts one burst and records outputs per cycle (index 1 = first cycle after the start edge).
   task automatic run_burst(input bit sel, input logic typ, input logic [2:0] cnt,
                            input logic [39:0] data, input int pulse_at);
      sel0 = sel;
      for (int j = 0; j < 128; j++) begin
         tr_we[j] = 1'bx; tr_latch[j] = 1'bx; tr_busy[j] = 1'bx; tr_data[j] = 8'hxx;
      end
      tr_done_at = 0;
      @(negedge clk);
      latch_type = typ; count = cnt; data_in = data;
      if (sel) activate0 = 1'b1; else activate = 1'b1;
      for (int j = 1; j <= 100; j++) begin
         @(negedge clk);
         activate  = !sel && (j == pulse_at);
         activate0 = sel && (j == pulse_at);
         tr_we[j] = s_we; tr_latch[j] = s_latch; tr_busy[j] = s_busy; tr_data[j] = s_data;
         if (s_done === 1'b1) begin
            tr_done_at = j;
            break;
         end
      end
      activate = 1'b0; activate0 = 1'b0;
   endtask

   task automatic test_reset();
      nreset = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
      checks++; if (write_enable !== 1'b1) begin errors++; $display("FAIL reset_we got %b want 1", write_enable); end
      checks++; if (latch_ctrl !== 1'b0) begin errors++; $display("FAIL reset_latch got %b want 0", latch_ctrl); end
      checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", data_out); end
      checks++; if (busy_0 !== 1'b0) begin errors++; $display("FAIL reset_busy0 got %b want 0", busy_0); end
      nreset = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_cmd();
      run_burst(1'b0, 1'b0, 3'd0, 40'h70, 0);
      checks++; if (tr_done_at !== CMD_LEN + 1) begin errors++; $display("FAIL cmd_done_cycle got %0d want %0d", tr_done_at, CMD_LEN + 1); end
      for (int j = 1; j <= 5; j++) begin
         checks++;
         if (tr_we[j] !== (j > 3) || tr_latch[j] !== 1'b1 || tr_data[j] !== 8'h70 || tr_busy[j] !== 1'b1) begin
            errors++;
            $display("FAIL cmd_cycle%0d got we=%b le=%b d=%h b=%b want we=%b le=1 d=70 b=1",
                     j, tr_we[j], tr_latch[j], tr_data[j], tr_busy[j], (j > 3));
         end
      end
      for (int j = 6; j <= CMD_LEN; j++) begin
         checks++;
         if (tr_we[j] !== 1'b1 || tr_latch[j] !== 1'b0 || tr_data[j] !== 8'h00 || tr_busy[j] !== 1'b1) begin
            errors++;
            $display("FAIL cmd_wb_cycle%0d got we=%b le=%b d=%h b=%b want we=1 le=0 d=00 b=1",
                     j, tr_we[j], tr_latch[j], tr_data[j], tr_busy[j]);
         end
      end
      checks++;
      if (tr_busy[CMD_LEN + 1] !== 1'b0 || tr_data[CMD_LEN + 1] !== 8'h00) begin
         errors++;
         $display("FAIL cmd_idle got b=%b d=%h want b=0 d=00", tr_busy[CMD_LEN + 1], tr_data[CMD_LEN + 1]);
      end
   endtask

   task automatic test_addr();
      logic [7:0] aw [0:4];
      int pulses;
      aw[0] = 8'h00; aw[1] = 8'h00; aw[2] = 8'h10; aw[3] = 8'h00; aw[4] = 8'h01;
      run_burst(1'b0, 1'b1, 3'd4, {8'h01, 8'h00, 8'h10, 8'h00, 8'h00}, 0);
      checks++; if (tr_done_at !== 26) begin errors++; $display("FAIL addr_done_cycle got %0d want 26", tr_done_at); end
      pulses = 0;
      for (int j = 1; j <= 25; j++) begin
         if (tr_we[j] === 1'b0 && (j == 1 || tr_we[j-1] === 1'b1)) pulses++;
         checks++;
         if (tr_we[j] !== (((j - 1) % 5) >= 3) || tr_latch[j] !== 1'b1 ||
             tr_data[j] !== aw[(j - 1) / 5] || tr_busy[j] !== 1'b1) begin
            errors++;
            $display("FAIL addr_cycle%0d got we=%b le=%b d=%h b=%b want we=%b le=1 d=%h b=1",
                     j, tr_we[j], tr_latch[j], tr_data[j], tr_busy[j], (((j - 1) % 5) >= 3), aw[(j - 1) / 5]);
         end
      end
      checks++; if (pulses !== 5) begin errors++; $display("FAIL addr_we_pulses got %0d want 5", pulses); end
      @(negedge clk);
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL addr_single_done got %b want 0", done); end
   endtask

   task automatic test_clamp();
      run_burst(1'b0, 1'b1, 3'd7, {8'hA5, 8'hA4, 8'hA3, 8'hA2, 8'hA1}, 0);
      checks++; if (tr_done_at !== 26) begin errors++; $display("FAIL clamp_done_cycle got %0d want 26", tr_done_at); end
      checks++; if (tr_data[1] !== 8'hA1) begin errors++; $display("FAIL clamp_first_word got %h want a1", tr_data[1]); end
      checks++;
      if (tr_data[21] !== 8'hA5 || tr_we[21] !== 1'b0) begin
         errors++; $display("FAIL clamp_last_word got d=%h we=%b want d=a5 we=0", tr_data[21], tr_we[21]);
      end
   endtask

   task automatic test_reset_mid();
      bit saw_done;
      sel0 = 1'b0;
      @(negedge clk);
      latch_type = 1'b1; count = 3'd4; data_in = {8'h01, 8'h00, 8'h10, 8'h00, 8'h00}; activate = 1'b1;
      for (int j = 1; j <= 11; j++) begin
         @(negedge clk);
         activate = 1'b0;
      end
      checks++;
      if (data_out !== 8'h10 || write_enable !== 1'b0) begin
         errors++; $display("FAIL rstmid_word3 got d=%h we=%b want d=10 we=0", data_out, write_enable);
      end
      nreset = 1'b0;
      activate = 1'b1;
      @(negedge clk);
      activate = 1'b0;
      checks++;
      if (busy !== 1'b0 || write_enable !== 1'b1 || latch_ctrl !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_abort got b=%b we=%b le=%b dn=%b want b=0 we=1 le=0 dn=0",
                  busy, write_enable, latch_ctrl, done);
      end
      nreset = 1'b1;
      saw_done = 1'b0;
      for (int j = 0; j < 8; j++) begin
         @(negedge clk);
         if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
      end
      checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL rstmid_quiet got activity=%b want 0", saw_done); end
      run_burst(1'b0, 1'b0, 3'd0, 40'h70, 0);
      checks++; if (tr_done_at !== CMD_LEN + 1) begin errors++; $display("FAIL rstmid_rerun got %0d want %0d", tr_done_at, CMD_LEN + 1); end
   endtask

   task automatic test_ignore();
      bit restarted;
      run_burst(1'b0, 1'b0, 3'd0, 40'h70, 2);
      checks++; if (tr_done_at !== CMD_LEN + 1) begin errors++; $display("FAIL ignore_done_cycle got %0d want %0d", tr_done_at, CMD_LEN + 1); end
      restarted = 1'b0;
      for (int j = 0; j < 4; j++) begin
         @(negedge clk);
         if (busy !== 1'b0) restarted = 1'b1;
      end
      checks++; if (restarted !== 1'b0) begin errors++; $display("FAIL ignore_no_queue got restarted=%b want 0", restarted); end
   endtask

   task automatic test_back_to_back();
      int d1, d2;
      logic b_after, we_after;
      d1 = 0; d2 = 0; b_after = 1'bx; we_after = 1'bx;
      sel0 = 1'b0;
      @(negedge clk);
      latch_type = 1'b0; count = 3'd0; data_in = 40'h70; activate = 1'b1;
      for (int j = 1; j <= 60; j++) begin
         @(negedge clk);
         if (d1 != 0 && j == d1 + 1) begin b_after = busy; we_after = write_enable; end
         if (done === 1'b1) begin
            if (d1 == 0) d1 = j;
            else begin
               d2 = j;
               activate = 1'b0;
               break;
            end
         end
      end
      activate = 1'b0;
      checks++; if (d1 !== CMD_LEN + 1) begin errors++; $display("FAIL b2b_first_done got %0d want %0d", d1, CMD_LEN + 1); end
      checks++;
      if (b_after !== 1'b1 || we_after !== 1'b0) begin
         errors++; $display("FAIL b2b_restart got b=%b we=%b want b=1 we=0", b_after, we_after);
      end
      checks++; if (d2 !== 2 * (CMD_LEN + 1)) begin errors++; $display("FAIL b2b_second_done got %0d want %0d", d2, 2 * (CMD_LEN + 1)); end
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_stop got b=%b want 0", busy); end
   endtask

   task automatic test_twp0();
      run_burst(1'b1, 1'b0, 3'd0, 40'h70, 0);
      checks++; if (tr_done_at !== 4 + WB) begin errors++; $display("FAIL twp0_done_cycle got %0d want %0d", tr_done_at, 4 + WB); end
      checks++;
      if (tr_we[1] !== 1'b0 || tr_we[2] !== 1'b1 || tr_we[3] !== 1'b1 || tr_latch[3] !== 1'b1) begin
         errors++;
         $display("FAIL twp0_pulse got we=%b%b%b le3=%b want we=011 le3=1", tr_we[1], tr_we[2], tr_we[3], tr_latch[3]);
      end
   endtask

   initial begin
      test_reset();
      test_cmd();
      test_addr();
      test_clamp();
      test_reset_mid();
      test_ignore();
      test_back_to_back();
      test_twp0();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
